// File: rtl/ext_interrupt_controller.sv
// External interrupt controller: edge-latched sources, fixed priority,
// toggle-acknowledged request handshake towards the core.
`timescale 1ns/1ps
module ext_interrupt_controller #(
  parameter int N_SRC        = 8,
  parameter int ID_W         = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int LOW_CYCLES   = 4
) (
  input  logic             Sys_Clock,
  input  logic             Sys_Reset,
  input  logic [N_SRC-1:0] Src_Irq,
  input  logic             Cfg_MaskWe,
  input  logic [N_SRC-1:0] Cfg_MaskData,
  output logic [N_SRC-1:0] Cfg_Mask,
  output logic [N_SRC-1:0] Pending,
  output logic             EIC_IntReq,
  output logic [ID_W-1:0]  EIC_IntId,
  input  logic             EIC_IntAck,
  output logic             Busy
);

  if (N_SRC < 2 || N_SRC > 16)
    $error("N_SRC out of range");
  if ((2 ** ID_W) < N_SRC)
    $error("ID_W too narrow");
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15)
    $error("SETUP_CYCLES out of range");
  if (LOW_CYCLES < 3 || LOW_CYCLES > 15)
    $error("LOW_CYCLES out of range");

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    RELEASE
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] srcLast;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clrMask;
  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  selId;
  logic             ackS1;
  logic             ackSync;
  logic             ackLast;
  logic             ackEvt;
  logic [3:0]       cnt;

  assign rise   = Src_Irq & ~srcLast;
  assign cand   = Pending & Cfg_Mask;
  assign ackEvt = ackSync ^ ackLast;
  assign Busy   = (state != IDLE);

  // Descending scan so the lowest set index is written last.
  always_comb begin
    selId = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (cand[i]) selId = ID_W'(i);
  end

  always_comb begin
    clrMask = '0;
    if (state == REQ && ackEvt)
      clrMask[EIC_IntId] = 1'b1;
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      srcLast  <= '0;
      Pending  <= '0;
      Cfg_Mask <= '0;
      ackS1    <= 1'b0;
      ackSync  <= 1'b0;
      ackLast  <= 1'b0;
    end else begin
      srcLast <= Src_Irq;
      // A fresh edge beats the ack clear.
      Pending <= (Pending & ~clrMask) | rise;
      if (Cfg_MaskWe)
        Cfg_Mask <= Cfg_MaskData;
      ackS1   <= EIC_IntAck;
      ackSync <= ackS1;
      ackLast <= ackSync;
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state      <= IDLE;
      EIC_IntReq <= 1'b0;
      EIC_IntId  <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|cand) begin
            EIC_IntId <= selId;
            cnt       <= 4'(SETUP_CYCLES - 1);
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            EIC_IntReq <= 1'b1;
            state      <= REQ;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REQ: begin
          if (ackEvt) begin
            EIC_IntReq <= 1'b0;
            cnt        <= 4'(LOW_CYCLES - 1);
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_interrupt_controller.sv
// Directed bench for ext_interrupt_controller with a toggle-ack
// core model and a 2-flop sync + edge detector on the request.
`timescale 1ns/1ps
module tb_ext_interrupt_controller;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] src = '0;
  logic       maskWe = 1'b0;
  logic [7:0] maskData = '0;
  logic [7:0] mask;
  logic [7:0] pend;
  logic       req;
  logic [2:0] id;
  logic       ack = 1'b0;
  logic       busy;

  int nRun = 0;
  int nFail = 0;

  logic cs1 = 1'b0;
  logic cs2 = 1'b0;
  logic cLast = 1'b0;
  int   riseCnt = 0;

  ext_interrupt_controller dut (
    .Sys_Clock    (clk),
    .Sys_Reset    (rstN),
    .Src_Irq      (src),
    .Cfg_MaskWe   (maskWe),
    .Cfg_MaskData (maskData),
    .Cfg_Mask     (mask),
    .Pending      (pend),
    .EIC_IntReq   (req),
    .EIC_IntId    (id),
    .EIC_IntAck   (ack),
    .Busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cs1   <= req;
    cs2   <= cs1;
    cLast <= cs2;
    if (cs2 && !cLast)
      riseCnt <= riseCnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nRun++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setMask(input logic [7:0] m);
    maskWe   = 1'b1;
    maskData = m;
    tick();
    maskWe   = 1'b0;
    check("maskWr", 32'(mask), 32'(m));
  endtask

  task automatic pulse(input int idx);
    src[idx] = 1'b1;
    tick();
    src[idx] = 1'b0;
  endtask

  task automatic waitReq(input string tag, input logic [2:0] expId);
    int n;
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_reqUp"}, 32'(req), 32'd1);
    check({tag, "_id"}, 32'(id), 32'(expId));
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_reqLow"}, 32'(req), 32'd0);
  endtask

  initial begin
    int n;
    int r0;

    tick();
    tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_mask", 32'(mask), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstN = 1'b1;
    tick();
    setMask(8'hFF);

    // single source, exact timing
    pulse(5);
    check("t1_pend", 32'(pend), 32'h20);
    check("t1_busy0", 32'(busy), 32'd0);
    tick();
    check("t1_s1id", 32'(id), 32'd5);
    check("t1_s1req", 32'(req), 32'd0);
    check("t1_s1busy", 32'(busy), 32'd1);
    tick();
    check("t1_s2id", 32'(id), 32'd5);
    check("t1_s2req", 32'(req), 32'd0);
    tick();
    check("t1_req", 32'(req), 32'd1);
    ack = ~ack;
    n = 0;
    while (req && n < 6) begin
      tick();
      n++;
    end
    check("t1_ackLat", 32'(n), 32'd3);
    check("t1_pendClr", 32'(pend), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_lowReq", 32'(req), 32'd0);
      check("t1_lowBusy", 32'(busy), 32'd1);
    end
    tick();
    check("t1_done", 32'(busy), 32'd0);

    // simultaneous 2 and 6
    tick();
    tick();
    tick();
    r0 = riseCnt;
    src = 8'h44;
    tick();
    src = 8'h00;
    check("t2_pend", 32'(pend), 32'h44);
    waitReq("t2a", 3'd2);
    ack = ~ack;
    n = 0;
    while (req && n < 6) begin
      tick();
      n++;
    end
    check("t2_pend6", 32'(pend), 32'h40);
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    check("t2_lowLen", 32'(n), 32'd7);
    check("t2b_id", 32'(id), 32'd6);
    tick();
    tick();
    tick();
    check("t2_coreRise", 32'(riseCnt - r0), 32'd2);
    ack = ~ack;
    waitIdle("t2b");
    check("t2_pendClr", 32'(pend), 32'd0);

    // masked source latches but waits for enable
    setMask(8'h01);
    pulse(3);
    check("t3_pend", 32'(pend), 32'h08);
    for (int i = 0; i < 5; i++)
      tick();
    check("t3_noReq", 32'(req), 32'd0);
    check("t3_noBusy", 32'(busy), 32'd0);
    setMask(8'h08);
    waitReq("t3", 3'd3);
    ack = ~ack;
    waitIdle("t3");
    check("t3_pendClr", 32'(pend), 32'd0);
    setMask(8'hFF);

    // re-arrival in the ack-clear cycle
    pulse(4);
    waitReq("t4a", 3'd4);
    ack = ~ack;
    tick();
    tick();
    check("t4_stillReq", 32'(req), 32'd1);
    src[4] = 1'b1;
    tick();
    src[4] = 1'b0;
    check("t4_reqDrop", 32'(req), 32'd0);
    check("t4_pendKept", 32'(pend), 32'h10);
    waitIdle("t4a");
    waitReq("t4b", 3'd4);
    ack = ~ack;
    waitIdle("t4b");
    check("t4_pendClr", 32'(pend), 32'd0);

    // spurious ack while idle
    ack = ~ack;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_idleBusy", 32'(busy), 32'd0);
    end
    pulse(1);
    waitReq("t5", 3'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_holdReq", 32'(req), 32'd1);
    end
    ack = ~ack;
    waitIdle("t5");
    check("t5_pendClr", 32'(pend), 32'd0);

    // reset mid-request
    pulse(7);
    waitReq("t6", 3'd7);
    rstN = 1'b0;
    #1;
    check("t6_req", 32'(req), 32'd0);
    check("t6_pend", 32'(pend), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_id", 32'(id), 32'd0);
    check("t6_mask", 32'(mask), 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    setMask(8'hFF);
    for (int i = 0; i < 10; i++)
      tick();
    check("t6_noReq", 32'(req), 32'd0);
    check("t6_noBusy", 32'(busy), 32'd0);
    check("t6_noPend", 32'(pend), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/ext_interrupt_controller.md
Name: ext_interrupt_controller

Overview:
- External Interrupt Controller (EIC): the initiator end of the core interrupt handshake.
- Collects N_SRC peripheral interrupt lines into edge-latched pending bits and applies an enable mask.
- Selects the highest-priority pending, enabled source and presents its ID to the core.
- Raises EIC_IntReq, waits for the core's toggle-style acknowledge, clears that source's pending bit, then returns EIC_IntReq low for a guaranteed minimum time so the core's synchronizer and rising-edge detector see every request.

Parameters:
- N_SRC, 8, number of interrupt sources; legal range 2..16.
- ID_W, 3, width of EIC_IntId; must satisfy 2**ID_W >= N_SRC and match the core-side ID width.
- SETUP_CYCLES, 2, cycles EIC_IntId is stable before EIC_IntReq rises; legal range 1..15.
- LOW_CYCLES, 4, minimum cycles EIC_IntReq stays low between requests; legal range 3..15, so the core's 2-flop synchronizer plus edge detector observe the low level.

Ports:
- Sys_Clock  input  1  system clock; all state updates on the rising edge.
- Sys_Reset  input  1  asynchronous, active-low reset.
- Src_Irq  input  N_SRC  peripheral interrupt lines; a rising edge marks the source pending.
- Cfg_MaskWe  input  1  write strobe for the enable mask.
- Cfg_MaskData  input  N_SRC  new enable mask; 1 = enabled.
- Cfg_Mask  output  N_SRC  current enable mask.
- Pending  output  N_SRC  current pending bits.
- EIC_IntReq  output  1  interrupt request level to the core.
- EIC_IntId  output  ID_W  ID of the requested source; stable from SETUP entry until RELEASE exit.
- EIC_IntAck  input  1  acknowledge from the core; every level toggle is one acknowledge.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, Sys_Reset=0): all of the following are cleared.
  - EIC_IntReq=0, EIC_IntId=0, Pending=0, Cfg_Mask=0, Busy=0, state=IDLE.
  - Src_Irq last-value registers=0.
  - Ack synchronizer (2 flops) and ack-last register=0; the core also resets its ack to 0.
  - Setup/low counter=0.
  - Reset mid-handshake aborts the transaction with no pending state retained.
- Source latching (every cycle):
  - Rising edge (Src_Irq[i]=1 and registered previous value=0) sets Pending[i].
  - Masked sources still latch pending; they are only excluded from selection.
  - A set and a clear of the same bit in the same cycle: set wins.
- Mask: Cfg_MaskWe=1 loads Cfg_MaskData on the next edge. Masking the in-flight source does not cancel an outstanding request.
- Selection: Candidates = Pending & Cfg_Mask. The lowest index has highest priority. ID = index, zero-extended to ID_W.
- Ack detect:
  - AckSync is 2-flop synchronized EIC_IntAck.
  - AckEvt = AckSync ^ AckLast, with AckLast <= AckSync.
  - Latency from an EIC_IntAck toggle to AckEvt is 2-3 cycles.
- FSM:
  - IDLE:
    - If Candidates != 0: latch EIC_IntId = selected ID and Cur = that index, load counter = SETUP_CYCLES-1, go to SETUP.
    - Otherwise stay in IDLE.
  - SETUP: EIC_IntReq=0. Decrement the counter; at 0, go to REQ. The ID is frozen; new higher-priority arrivals wait for the next transaction.
  - REQ:
    - EIC_IntReq=1 (registered; first high cycle is the cycle after leaving SETUP).
    - On AckEvt: clear Pending[Cur], EIC_IntReq<=0, load counter = LOW_CYCLES-1, go to RELEASE.
    - No timeout.
  - RELEASE: EIC_IntReq=0. Decrement the counter; at 0, go to IDLE. EIC_IntId is held until exit.
  - AckEvt outside REQ (a spurious toggle) is ignored, and AckLast still tracks AckSync.
- Minimum IDLE-to-IDLE transaction length = SETUP_CYCLES + 1 (REQ) + 2..3 (ack sync) + LOW_CYCLES. Back-to-back requests re-enter SETUP from IDLE on the cycle after RELEASE exits.
- Busy = (state != IDLE).

Test Plan:
- Reset, Cfg_Mask=8'hFF, pulse Src_Irq[5] -> Pending=8'h20; EIC_IntId=5 for 2 cycles with EIC_IntReq=0, then EIC_IntReq=1. Core model toggles EIC_IntAck -> EIC_IntReq=0 within 3 cycles, Pending=0, EIC_IntReq held 0 for >=4 cycles, Busy returns 0.
- Src_Irq[2] and Src_Irq[6] rise in the same cycle -> ID 2 is served first. After the ack and the 4-cycle low, ID 6 is served. The second EIC_IntReq rising edge is seen by a core model using 2-flop sync plus edge detect.
- Cfg_Mask=8'h01, pulse Src_Irq[3] -> Pending[3]=1, no request. Write Cfg_Mask=8'h08 -> request with ID 3 follows.
- During REQ for ID 4, Src_Irq[4] rises again in the ack-clear cycle -> Pending[4] remains 1 and a second ID-4 transaction follows.
- Toggle EIC_IntAck while in IDLE -> no state change. Then raise Src_Irq[1] -> normal transaction with ID 1; a single later toggle completes it.
- Assert Sys_Reset in REQ -> EIC_IntReq, Pending, Busy and EIC_IntId are all 0 immediately. After release with no source edges, no request is issued.
